// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/bubble sequencer with data-memory req/ack timeout FSM.
// Optional HAZARD_PERF_CNT_EN builds saturating performance counters.
module hazard_stall_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Load_EX,
    input  logic [4:0]        Rw_EX,
    input  logic [4:0]        Rs_ID,
    input  logic [4:0]        Rt_ID,
    input  logic              UseRs_ID,
    input  logic              UseRt_ID,
    input  logic              BranchTaken_EX,
    input  logic              Jump_ID,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              stall_id_ex,
    output logic              stall_ex_mem,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              bubble_mem_wb,
    output logic              mem_err,
    output logic [PERF_W-1:0] load_use_cnt,
    output logic [PERF_W-1:0] mem_stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] tcnt;

    logic access;
    logic req;
    logic ack;
    logic abort;
    logic mem_stall;
    logic lu_raw;
    logic br;
    logic lu;
    logic jmp;

    assign access = MemRead_MEM | MemWrite_MEM;
    assign req    = !reset & ((state == WAIT) | access);
    assign ack    = req & dmem_ack;

    // tcnt counts request cycles; it is 0 on the first (IDLE) cycle
    assign abort     = req & !ack & (tcnt == TLAST);
    assign mem_stall = req & !ack & !abort;

    assign lu_raw = Load_EX & (Rw_EX != 5'd0) &
                    ((UseRs_ID & (Rs_ID == Rw_EX)) |
                     (UseRt_ID & (Rt_ID == Rw_EX)));

    assign br  = !reset & !mem_stall & BranchTaken_EX;
    assign lu  = !reset & !mem_stall & !BranchTaken_EX & lu_raw;
    assign jmp = !reset & !mem_stall & !BranchTaken_EX
               & !lu_raw & Jump_ID;

    assign dmem_req      = req;
    assign stall_pc      = mem_stall | lu;
    assign stall_if_id   = mem_stall | lu;
    assign stall_id_ex   = mem_stall;
    assign stall_ex_mem  = mem_stall;
    assign bubble_mem_wb = mem_stall;
    assign flush_if_id   = br | jmp;
    assign flush_id_ex   = br | lu;
    assign mem_err       = abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_stall) begin
                        state <= WAIT;
                        tcnt  <= 16'd1;
                    end
                end
                WAIT: begin
                    if (ack | abort) begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] lu_q;
    logic [PERF_W-1:0] ms_q;
    logic [PERF_W-1:0] fl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_q <= '0;
            ms_q <= '0;
            fl_q <= '0;
        end else begin
            if (lu && !(&lu_q))
                lu_q <= lu_q + 1'b1;
            if (mem_stall && !(&ms_q))
                ms_q <= ms_q + 1'b1;
            if ((flush_if_id | flush_id_ex) && !(&fl_q))
                fl_q <= fl_q + 1'b1;
        end
    end

    assign load_use_cnt  = lu_q;
    assign mem_stall_cnt = ms_q;
    assign flush_cnt     = fl_q;
`else
    assign load_use_cnt  = '0;
    assign mem_stall_cnt = '0;
    assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (TIMEOUT_CYC=4).
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Load_EX;
    logic [4:0]  Rw_EX;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic        UseRs_ID;
    logic        UseRt_ID;
    logic        BranchTaken_EX;
    logic        Jump_ID;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic        dmem_ack;
    logic        dmem_req;
    logic        stall_pc;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        stall_ex_mem;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        bubble_mem_wb;
    logic        mem_err;
    logic [31:0] load_use_cnt;
    logic [31:0] mem_stall_cnt;
    logic [31:0] flush_cnt;

    int checks = 0;
    int errors = 0;
    int lu_m = 0;
    int ms_m = 0;
    int fl_m = 0;

    // {req, spc, sif, sidex, sexm, fif, fidex, bub, err}
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b011000100;
    localparam logic [8:0] MS   = 9'b111110010;
    localparam logic [8:0] REQ  = 9'b100000000;
    localparam logic [8:0] ABRT = 9'b100000001;
    localparam logic [8:0] BR   = 9'b000001100;
    localparam logic [8:0] JMP  = 9'b000001000;
    localparam logic [8:0] ACKB = 9'b100001100;

    hazard_stall_ctrl #(.TIMEOUT_CYC(4), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .Load_EX(Load_EX), .Rw_EX(Rw_EX),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
        .BranchTaken_EX(BranchTaken_EX), .Jump_ID(Jump_ID),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .bubble_mem_wb(bubble_mem_wb), .mem_err(mem_err),
        .load_use_cnt(load_use_cnt),
        .mem_stall_cnt(mem_stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {dmem_req, stall_pc, stall_if_id, stall_id_ex,
                stall_ex_mem, flush_if_id, flush_id_ex,
                bubble_mem_wb, mem_err};
    endfunction

    task automatic clr();
        Load_EX = 0; Rw_EX = 0; Rs_ID = 0; Rt_ID = 0;
        UseRs_ID = 0; UseRt_ID = 0;
        BranchTaken_EX = 0; Jump_ID = 0;
        MemRead_MEM = 0; MemWrite_MEM = 0; dmem_ack = 0;
    endtask

    // called at negedge with inputs set; ends at next negedge
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        check(tag, 32'(outs()), 32'(exp));
        if (exp[7] && !exp[4]) lu_m++;
        if (exp[4]) ms_m++;
        if (exp[3] || exp[2]) fl_m++;
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_lu"}, load_use_cnt, 32'(lu_m));
        check({tag, "_ms"}, mem_stall_cnt, 32'(ms_m));
        check({tag, "_fl"}, flush_cnt, 32'(fl_m));
`else
        check({tag, "_lu"}, load_use_cnt, 32'd0);
        check({tag, "_ms"}, mem_stall_cnt, 32'd0);
        check({tag, "_fl"}, flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        clr();
        reset = 1;
        MemRead_MEM = 1; BranchTaken_EX = 1;
        Load_EX = 1; Rw_EX = 5; Rs_ID = 5; UseRs_ID = 1;
        #2;
        check("in_reset", 32'(outs()), 32'(NONE));
        chk_cnt("rst");
        @(negedge clk);
        clr();
        reset = 0;
        cyc("idle", NONE);

        Load_EX = 1; Rw_EX = 5; Rs_ID = 5; UseRs_ID = 1;
        cyc("lu_rs", LU);
        Load_EX = 0;
        cyc("lu_rs_clear", NONE);
        Load_EX = 1; Rw_EX = 7; Rt_ID = 7; UseRt_ID = 1; UseRs_ID = 0;
        cyc("lu_rt", LU);
        UseRt_ID = 0;
        cyc("lu_rt_unused", NONE);
        Rw_EX = 0; Rs_ID = 0; UseRs_ID = 1;
        cyc("lu_r0", NONE);
        clr();
        chk_cnt("lu");

        MemRead_MEM = 1;
        cyc("rd_w1", MS);
        cyc("rd_w2", MS);
        cyc("rd_w3", MS);
        dmem_ack = 1;
        cyc("rd_ack", REQ);
        clr();
        dmem_ack = 1;
        cyc("ack_noreq", NONE);
        clr();
        chk_cnt("rd");

        MemWrite_MEM = 1; dmem_ack = 1;
        cyc("wr_zero", REQ);
        cyc("wr_b2b", REQ);
        clr();
        cyc("wr_done", NONE);

        MemRead_MEM = 1;
        cyc("to_w1", MS);
        cyc("to_w2", MS);
        cyc("to_w3", MS);
        cyc("to_abort", ABRT);
        MemRead_MEM = 0;
        cyc("to_idle", NONE);
        chk_cnt("to");

        BranchTaken_EX = 1;
        Load_EX = 1; Rw_EX = 3; Rs_ID = 3; UseRs_ID = 1;
        cyc("br_lu", BR);
        clr();
        Jump_ID = 1;
        cyc("jmp", JMP);
        Load_EX = 1; Rw_EX = 9; Rt_ID = 9; UseRt_ID = 1;
        cyc("jmp_lu", LU);
        clr();

        MemRead_MEM = 1; BranchTaken_EX = 1;
        cyc("br_ms1", MS);
        cyc("br_ms2", MS);
        dmem_ack = 1;
        cyc("br_ack", ACKB);
        clr();
        chk_cnt("ctl");

        MemRead_MEM = 1;
        cyc("rw_a", MS);
        cyc("rw_b", MS);
        reset = 1;
        #1;
        check("rst_wait", 32'(outs()), 32'(NONE));
        lu_m = 0; ms_m = 0; fl_m = 0;
        @(negedge clk);
        chk_cnt("rst_wait");
        MemRead_MEM = 0;
        reset = 0;
        cyc("post_rst", NONE);
        MemRead_MEM = 1; dmem_ack = 1;
        cyc("post_rst_req", REQ);
        clr();
        @(negedge clk);
        chk_cnt("end");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
